// File: rtl/sc_game_timebase.sv
// rtl/sc_game_timebase.sv - game countdown timer, car-step pacing and saturating point counter
// SC_GAME_TIMEBASE_PAUSE_EN adds SC_GAME_TIMEBASE_pause_InLow to freeze the timebase.
module sc_game_timebase #(
  parameter int PRESCALE_DIV = 50000000,
  parameter int TIMER_WIDTH  = 4,
  parameter int SPEED_WIDTH  = 4,
  parameter int POINT_WIDTH  = 8
) (
  input  logic                   SC_GAME_TIMEBASE_CLOCK_50,
  input  logic                   SC_GAME_TIMEBASE_RESET_InHigh,
  input  logic                   SC_GAME_TIMEBASE_timerLoad_InLow,
  input  logic [TIMER_WIDTH-1:0] SC_GAME_TIMEBASE_timer_InBUS,
  input  logic [SPEED_WIDTH-1:0] SC_GAME_TIMEBASE_speedCounter_InBUS,
  input  logic                   SC_GAME_TIMEBASE_pointInc_InLow,
  input  logic                   SC_GAME_TIMEBASE_pointClear_InLow,
`ifdef SC_GAME_TIMEBASE_PAUSE_EN
  input  logic                   SC_GAME_TIMEBASE_pause_InLow,
`endif
  output logic                   SC_GAME_TIMEBASE_timer_OutLow,
  output logic                   SC_GAME_TIMEBASE_speedComparator_OutLow,
  output logic [POINT_WIDTH-1:0] SC_GAME_TIMEBASE_pointCounter_OutBUS,
  output logic                   SC_GAME_TIMEBASE_busy_Out
);

  localparam int PW = (PRESCALE_DIV > 2) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(PRESCALE_DIV - 1);

  localparam logic [1:0] STATE_IDLE   = 2'd0;
  localparam logic [1:0] STATE_RUN    = 2'd1;
  localparam logic [1:0] STATE_EXPIRE = 2'd2;

  logic [1:0]             state;
  logic [PW-1:0]          prescaler;
  logic [TIMER_WIDTH-1:0] countdown;
  logic [TIMER_WIDTH-1:0] pendingValue;
  logic                   pendingLoad;
  logic [SPEED_WIDTH-1:0] step;

  logic                   running;
  logic                   load;
  logic                   tick;
  logic [TIMER_WIDTH-1:0] loadValue;
  logic [SPEED_WIDTH:0]   stepNext;
  logic [SPEED_WIDTH:0]   period;

`ifdef SC_GAME_TIMEBASE_PAUSE_EN
  assign running = SC_GAME_TIMEBASE_pause_InLow;
`else
  assign running = 1'b1;
`endif

  assign load      = ~SC_GAME_TIMEBASE_timerLoad_InLow;
  assign tick      = (state == STATE_RUN) && running && (prescaler == PRESCALE_LAST);
  assign loadValue = load ? SC_GAME_TIMEBASE_timer_InBUS : pendingValue;
  assign stepNext  = {1'b0, step} + (SPEED_WIDTH+1)'(1);
  assign period    = (SC_GAME_TIMEBASE_speedCounter_InBUS == '0) ? (SPEED_WIDTH+1)'(1)
                                                                 : {1'b0, SC_GAME_TIMEBASE_speedCounter_InBUS};

  always_ff @(posedge SC_GAME_TIMEBASE_CLOCK_50 or posedge SC_GAME_TIMEBASE_RESET_InHigh) begin
    if (SC_GAME_TIMEBASE_RESET_InHigh) begin
      state                                   <= STATE_IDLE;
      prescaler                               <= '0;
      countdown                               <= '0;
      step                                    <= '0;
      pendingLoad                             <= 1'b0;
      pendingValue                            <= '0;
      SC_GAME_TIMEBASE_busy_Out               <= 1'b0;
      SC_GAME_TIMEBASE_timer_OutLow           <= 1'b1;
      SC_GAME_TIMEBASE_speedComparator_OutLow <= 1'b1;
    end else begin
      SC_GAME_TIMEBASE_timer_OutLow           <= 1'b1;
      SC_GAME_TIMEBASE_speedComparator_OutLow <= 1'b1;
      case (state)
        STATE_IDLE: begin
          prescaler <= '0;
          step      <= '0;
          if (load || pendingLoad) begin
            countdown   <= loadValue;
            pendingLoad <= 1'b0;
            if (loadValue == '0) begin
              state                         <= STATE_EXPIRE;
              SC_GAME_TIMEBASE_timer_OutLow <= 1'b0;
            end else begin
              state                     <= STATE_RUN;
              SC_GAME_TIMEBASE_busy_Out <= 1'b1;
            end
          end
        end
        STATE_RUN: begin
          // A restart swallows any tick that lands on the same cycle.
          if (load) begin
            countdown <= SC_GAME_TIMEBASE_timer_InBUS;
            prescaler <= '0;
            step      <= '0;
            if (SC_GAME_TIMEBASE_timer_InBUS == '0) begin
              state                         <= STATE_EXPIRE;
              SC_GAME_TIMEBASE_busy_Out     <= 1'b0;
              SC_GAME_TIMEBASE_timer_OutLow <= 1'b0;
            end
          end else if (tick) begin
            prescaler <= '0;
            if (countdown == TIMER_WIDTH'(1)) begin
              countdown                     <= '0;
              step                          <= '0;
              state                         <= STATE_EXPIRE;
              SC_GAME_TIMEBASE_busy_Out     <= 1'b0;
              SC_GAME_TIMEBASE_timer_OutLow <= 1'b0;
            end else begin
              countdown <= countdown - TIMER_WIDTH'(1);
              if (stepNext >= period) begin
                step                                    <= '0;
                SC_GAME_TIMEBASE_speedComparator_OutLow <= 1'b0;
              end else begin
                step <= stepNext[SPEED_WIDTH-1:0];
              end
            end
          end else if (running) begin
            prescaler <= prescaler + PW'(1);
          end
        end
        STATE_EXPIRE: begin
          state                     <= STATE_IDLE;
          prescaler                 <= '0;
          step                      <= '0;
          SC_GAME_TIMEBASE_busy_Out <= 1'b0;
          // Held for one cycle so IDLE can act on it next.
          if (load) begin
            pendingLoad  <= 1'b1;
            pendingValue <= SC_GAME_TIMEBASE_timer_InBUS;
          end
        end
        default: begin
          state                     <= STATE_IDLE;
          SC_GAME_TIMEBASE_busy_Out <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge SC_GAME_TIMEBASE_CLOCK_50 or posedge SC_GAME_TIMEBASE_RESET_InHigh) begin
    if (SC_GAME_TIMEBASE_RESET_InHigh) begin
      SC_GAME_TIMEBASE_pointCounter_OutBUS <= '0;
    end else if (!SC_GAME_TIMEBASE_pointClear_InLow) begin
      SC_GAME_TIMEBASE_pointCounter_OutBUS <= '0;
    end else if (!SC_GAME_TIMEBASE_pointInc_InLow && (SC_GAME_TIMEBASE_pointCounter_OutBUS != '1)) begin
      SC_GAME_TIMEBASE_pointCounter_OutBUS <= SC_GAME_TIMEBASE_pointCounter_OutBUS + POINT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_sc_game_timebase.sv
// tb/tb_sc_game_timebase.sv - self-checking bench for sc_game_timebase (PRESCALE_DIV=4)
module tb_sc_game_timebase;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       loadLow;
  logic [3:0] timerBus;
  logic [3:0] speedBus;
  logic       incLow;
  logic       clrLow;
  logic       timerLow;
  logic       speedLow;
  logic [7:0] points;
  logic       busy;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  sc_game_timebase #(
    .PRESCALE_DIV(DIV),
    .TIMER_WIDTH (4),
    .SPEED_WIDTH (4),
    .POINT_WIDTH (8)
  ) dut (
    .SC_GAME_TIMEBASE_CLOCK_50              (clk),
    .SC_GAME_TIMEBASE_RESET_InHigh          (rst),
    .SC_GAME_TIMEBASE_timerLoad_InLow       (loadLow),
    .SC_GAME_TIMEBASE_timer_InBUS           (timerBus),
    .SC_GAME_TIMEBASE_speedCounter_InBUS    (speedBus),
    .SC_GAME_TIMEBASE_pointInc_InLow        (incLow),
    .SC_GAME_TIMEBASE_pointClear_InLow      (clrLow),
    .SC_GAME_TIMEBASE_timer_OutLow          (timerLow),
    .SC_GAME_TIMEBASE_speedComparator_OutLow(speedLow),
    .SC_GAME_TIMEBASE_pointCounter_OutBUS   (points),
    .SC_GAME_TIMEBASE_busy_Out              (busy)
  );

  typedef struct {
    int v;
    int s;
    int reloadAt;
    int reloadV;
    int expAt;
    int expCnt;
    int busyCnt;
    int stepCnt;
    int firstStep;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tickClk();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst      = 1'b1;
    loadLow  = 1'b1;
    incLow   = 1'b1;
    clrLow   = 1'b1;
    timerBus = '0;
    speedBus = '0;
    tickClk();
    rst = 1'b0;
  endtask

  initial begin
    int expAt, expCnt, busyCnt, stepCnt, firstStep, lowCnt;
    bit have, pend;
    int lc, mv, mp, pendV, pendP, mpts, d, v, s;
    bit eb, et, es, doLoad, doInc, doClr;

    vecs[0] = '{v:3,  s:1,  reloadAt:-1, reloadV:0, expAt:13, expCnt:1, busyCnt:12, stepCnt:2, firstStep:5};
    vecs[1] = '{v:0,  s:2,  reloadAt:-1, reloadV:0, expAt:1,  expCnt:1, busyCnt:0,  stepCnt:0, firstStep:-1};
    vecs[2] = '{v:5,  s:2,  reloadAt:-1, reloadV:0, expAt:21, expCnt:1, busyCnt:20, stepCnt:2, firstStep:9};
    vecs[3] = '{v:5,  s:2,  reloadAt:6,  reloadV:2, expAt:15, expCnt:1, busyCnt:14, stepCnt:0, firstStep:-1};
    vecs[4] = '{v:1,  s:0,  reloadAt:-1, reloadV:0, expAt:5,  expCnt:1, busyCnt:4,  stepCnt:0, firstStep:-1};
    vecs[5] = '{v:4,  s:0,  reloadAt:-1, reloadV:0, expAt:17, expCnt:1, busyCnt:16, stepCnt:3, firstStep:5};
    vecs[6] = '{v:15, s:15, reloadAt:-1, reloadV:0, expAt:61, expCnt:1, busyCnt:60, stepCnt:0, firstStep:-1};
    vecs[7] = '{v:6,  s:3,  reloadAt:-1, reloadV:0, expAt:25, expCnt:1, busyCnt:24, stepCnt:1, firstStep:13};

    resetDut();
    check("reset_timerLow", timerLow, 1);
    check("reset_speedLow", speedLow, 1);
    check("reset_busy", busy, 0);
    check("reset_points", points, 0);

    for (int i = 0; i < 8; i++) begin
      resetDut();
      timerBus = vecs[i].v[3:0];
      speedBus = vecs[i].s[3:0];
      loadLow  = 1'b0;
      tickClk();
      loadLow = 1'b1;
      expAt = -1; expCnt = 0; busyCnt = 0; stepCnt = 0; firstStep = -1;
      for (int c = 1; c <= 70; c++) begin
        if (timerLow === 1'b0) begin
          expCnt++;
          if (expAt < 0) expAt = c;
        end
        if (busy === 1'b1) busyCnt++;
        if (speedLow === 1'b0) begin
          stepCnt++;
          if (firstStep < 0) firstStep = c;
        end
        if (c == 1) check($sformatf("vec%0d_busy_next", i), busy, (vecs[i].v != 0) ? 1 : 0);
        if (c == vecs[i].reloadAt) begin
          timerBus = vecs[i].reloadV[3:0];
          loadLow  = 1'b0;
        end else begin
          loadLow = 1'b1;
        end
        tickClk();
      end
      check($sformatf("vec%0d_expAt", i), expAt, vecs[i].expAt);
      check($sformatf("vec%0d_expCnt", i), expCnt, vecs[i].expCnt);
      check($sformatf("vec%0d_busyCnt", i), busyCnt, vecs[i].busyCnt);
      check($sformatf("vec%0d_stepCnt", i), stepCnt, vecs[i].stepCnt);
      check($sformatf("vec%0d_firstStep", i), firstStep, vecs[i].firstStep);
    end

    // Load arriving while the expiry pulse is out is carried into IDLE.
    resetDut();
    timerBus = 4'd0;
    loadLow  = 1'b0;
    tickClk();
    check("latch_expire_pulse", timerLow, 0);
    timerBus = 4'd2;
    tickClk();
    loadLow = 1'b1;
    for (int c = 2; c <= 12; c++) begin
      check($sformatf("latch_busy_c%0d", c), busy, (c >= 3 && c <= 10) ? 1 : 0);
      check($sformatf("latch_timer_c%0d", c), timerLow, (c == 11) ? 0 : 1);
      tickClk();
    end

    resetDut();
    incLow = 1'b0;
    repeat (255) tickClk();
    check("points_255", points, 255);
    tickClk();
    check("points_sat", points, 255);
    clrLow = 1'b0;
    tickClk();
    check("points_clear_beats_inc", points, 0);
    clrLow = 1'b1;
    tickClk();
    check("points_after_clear", points, 1);
    incLow = 1'b1;

    // Asynchronous reset while the countdown sits at 2.
    resetDut();
    incLow   = 1'b0;
    timerBus = 4'd3;
    speedBus = 4'd1;
    loadLow  = 1'b0;
    tickClk();
    loadLow = 1'b1;
    incLow  = 1'b1;
    repeat (5) tickClk();
    check("midrun_busy_before", busy, 1);
    check("midrun_points_before", points, 1);
    #2 rst = 1'b1;
    #1;
    check("midrun_busy", busy, 0);
    check("midrun_timerLow", timerLow, 1);
    check("midrun_speedLow", speedLow, 1);
    check("midrun_points", points, 0);
    tickClk();
    tickClk();
    rst = 1'b0;
    lowCnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (timerLow !== 1'b1 || speedLow !== 1'b1 || busy !== 1'b0) lowCnt++;
      tickClk();
    end
    check("midrun_no_activity", lowCnt, 0);

    // Randomized run against an event-schedule model.
    resetDut();
    have = 0; pend = 0; lc = 0; mv = 0; mp = 1; pendV = 0; pendP = 1; mpts = 0;
    for (int n = 0; n < 3000; n++) begin
      d  = n - lc;
      eb = have && mv > 0 && d >= 1 && d <= mv * DIV;
      et = have && d == ((mv == 0) ? 1 : mv * DIV + 1);
      es = have && mv > 0 && d > 1 && ((d - 1) % (mp * DIV)) == 0 && ((d - 1) / (mp * DIV)) * mp < mv;
      check("rand_busy", busy, eb);
      check("rand_timerLow", timerLow, !et);
      check("rand_speedLow", speedLow, !es);
      check("rand_points", points, mpts);

      if (pend) begin
        have = 1; lc = n; mv = pendV; mp = pendP; pend = 0;
      end
      doLoad = ($urandom_range(0, 29) == 0);
      doInc  = ($urandom_range(0, 2) == 0);
      doClr  = ($urandom_range(0, 19) == 0);
      loadLow = !doLoad;
      incLow  = !doInc;
      clrLow  = !doClr;
      if (doLoad) begin
        v = $urandom_range(0, 6);
        s = $urandom_range(0, 3);
        timerBus = v[3:0];
        speedBus = s[3:0];
        if (et) begin
          pend = 1; pendV = v; pendP = (s == 0) ? 1 : s;
        end else begin
          have = 1; lc = n; mv = v; mp = (s == 0) ? 1 : s;
        end
      end
      if (doClr) mpts = 0;
      else if (doInc && mpts < 255) mpts++;
      tickClk();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
